// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake,
// optional skid entry, flush, bubble insertion and stall counter.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter bit                SKID        = 1'b1,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nxt_state;

    logic [DATA_W-1:0]   r_m_data;
    logic [CTRL_W-1:0]   r_m_ctrl;
    logic [DATA_W-1:0]   r_s_data;
    logic [CTRL_W-1:0]   r_s_ctrl;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_acc;
    logic                w_pop;
    logic                w_stall;
    logic                w_load_m;
    logic                w_load_s;
    logic                w_shift;
    logic [CTRL_W-1:0]   w_in_ctrl;

    assign w_acc     = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_stall   = out_valid & ~out_ready;
    assign w_in_ctrl = bubble ? BUBBLE_CTRL : in_ctrl;

    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_m_data;
    // An empty stage always presents the NOP pattern downstream.
    assign out_ctrl  = out_valid ? r_m_ctrl : BUBBLE_CTRL;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

    generate
        if (SKID) begin : g_skid
            // Registered ready: only the full (two-entry) state blocks.
            assign in_ready = (r_state != ST_TWO);
        end else begin : g_noskid
            // Single entry: accept whenever the head leaves this cycle.
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    // Next-state and datapath-enable decode.
    always_comb begin
        w_nxt_state = r_state;
        w_load_m    = 1'b0;
        w_load_s    = 1'b0;
        w_shift     = 1'b0;
        if (flush) begin
            w_nxt_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_load_m    = 1'b1;
                        w_nxt_state = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_pop) begin
                        w_load_m = 1'b1;
                    end else if (w_acc && SKID) begin
                        w_load_s    = 1'b1;
                        w_nxt_state = ST_TWO;
                    end else if (w_pop) begin
                        w_nxt_state = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_shift     = 1'b1;
                        w_nxt_state = ST_ONE;
                    end
                end
                default: begin
                    w_nxt_state = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Main (head) entry: loaded from input or promoted from skid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_data <= '0;
            r_m_ctrl <= BUBBLE_CTRL;
        end else if (w_load_m) begin
            r_m_data <= in_data;
            r_m_ctrl <= w_in_ctrl;
        end else if (w_shift) begin
            r_m_data <= r_s_data;
            r_m_ctrl <= r_s_ctrl;
        end
    end

    // Skid entry: catches the beat accepted while the head is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_data <= '0;
            r_s_ctrl <= BUBBLE_CTRL;
        end else if (w_load_s) begin
            r_s_data <= in_data;
            r_s_ctrl <= w_in_ctrl;
        end
    end

    // Saturating count of cycles the head waits on downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: table-driven sequence on a
// SKID=1 instance plus hand sequences on a SKID=0, CNT_W=4 instance.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: default parameters (SKID=1, CNT_W=16)
    logic        a_rst, a_iv, a_ir, a_bub, a_fl, a_ov, a_ordy;
    logic [63:0] a_d, a_od;
    logic [15:0] a_c, a_oc, a_sc;
    logic [1:0]  a_occ;

    pipe_stage_reg u_a (
        .clk(clk), .reset(a_rst),
        .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_d), .in_ctrl(a_c),
        .bubble(a_bub), .flush(a_fl),
        .out_valid(a_ov), .out_ready(a_ordy),
        .out_data(a_od), .out_ctrl(a_oc),
        .occupancy(a_occ), .stall_cnt(a_sc)
    );

    // Instance B: SKID=0, CNT_W=4
    logic        b_rst, b_iv, b_ir, b_bub, b_fl, b_ov, b_ordy;
    logic [63:0] b_d, b_od;
    logic [15:0] b_c, b_oc;
    logic [3:0]  b_sc;
    logic [1:0]  b_occ;

    pipe_stage_reg #(.SKID(1'b0), .CNT_W(4)) u_b (
        .clk(clk), .reset(b_rst),
        .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_d), .in_ctrl(b_c),
        .bubble(b_bub), .flush(b_fl),
        .out_valid(b_ov), .out_ready(b_ordy),
        .out_data(b_od), .out_ctrl(b_oc),
        .occupancy(b_occ), .stall_cnt(b_sc)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [63:0] d;
        logic [15:0] c;
        logic        bub;
        logic        fl;
        logic        ordy;
        logic        ov;
        logic [63:0] od;
        logic [15:0] oc;
        logic [1:0]  occ;
        logic        ir;
        logic [15:0] sc;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic iv,
                       input logic [63:0] d, input logic [15:0] c,
                       input logic bub, input logic fl, input logic ordy,
                       input logic ov, input logic [63:0] od,
                       input logic [15:0] oc, input logic [1:0] occ,
                       input logic ir, input logic [15:0] sc);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.c = c;
        v.bub = bub; v.fl = fl; v.ordy = ordy;
        v.ov = ov; v.od = od; v.oc = oc;
        v.occ = occ; v.ir = ir; v.sc = sc;
        vt.push_back(v);
    endtask

    initial begin
        a_rst = 1; a_iv = 0; a_d = 0; a_c = 0;
        a_bub = 0; a_fl = 0; a_ordy = 0;
        b_rst = 1; b_iv = 0; b_d = 0; b_c = 0;
        b_bub = 0; b_fl = 0; b_ordy = 0;

        // rst iv data ctrl bub fl ordy | ov od oc occ ir sc
        add(1,0,64'h0,16'h0,0,0,0, 0,64'h0,16'h0,2'd0,1,16'd0);
        add(0,0,64'h0,16'h0,0,0,1, 0,64'h0,16'h0,2'd0,1,16'd0);
        // streaming 1..8
        for (int k = 1; k <= 8; k++)
            add(0,1,64'(k),16'h11,0,0,1,
                1,64'(k),16'h11,2'd1,1,16'd0);
        add(0,0,64'h0,16'h0,0,0,1, 0,64'h8,16'h0,2'd0,1,16'd0);
        // back-pressure A/B
        add(0,1,64'hAA,16'h22,0,0,0, 1,64'hAA,16'h22,2'd1,1,16'd0);
        add(0,1,64'hBB,16'h33,0,0,0, 1,64'hAA,16'h22,2'd2,0,16'd1);
        for (int k = 2; k <= 5; k++)
            add(0,0,64'h0,16'h0,0,0,0,
                1,64'hAA,16'h22,2'd2,0,16'(k));
        add(0,0,64'h0,16'h0,0,0,1, 1,64'hBB,16'h33,2'd1,1,16'd5);
        add(0,0,64'h0,16'h0,0,0,1, 0,64'hBB,16'h0,2'd0,1,16'd5);
        // bubble
        add(0,1,64'h1234,16'hFF,1,0,0, 1,64'h1234,16'h0,2'd1,1,16'd5);
        add(0,0,64'h0,16'h0,0,0,1, 0,64'h1234,16'h0,2'd0,1,16'd5);
        add(0,0,64'h9,16'h44,1,0,1, 0,64'h1234,16'h0,2'd0,1,16'd5);
        // flush from TWO with 0xCC offered
        add(0,1,64'h11,16'h55,0,0,0, 1,64'h11,16'h55,2'd1,1,16'd5);
        add(0,1,64'h22,16'h66,0,0,0, 1,64'h11,16'h55,2'd2,0,16'd6);
        add(0,1,64'hCC,16'h77,0,1,0, 0,64'h11,16'h0,2'd0,1,16'd7);
        add(0,0,64'h0,16'h0,0,0,1, 0,64'h11,16'h0,2'd0,1,16'd7);
        // flush in ONE with accept+pop: 0xCC dropped
        add(0,1,64'h33,16'h88,0,0,1, 1,64'h33,16'h88,2'd1,1,16'd7);
        add(0,1,64'hCC,16'h99,0,1,1, 0,64'h33,16'h0,2'd0,1,16'd7);
        add(0,0,64'h0,16'h0,0,0,1, 0,64'h33,16'h0,2'd0,1,16'd7);
        // reset mid-stream
        add(1,1,64'h44,16'h1,0,0,0, 0,64'h0,16'h0,2'd0,1,16'd0);
        add(0,0,64'h0,16'h0,0,0,1, 0,64'h0,16'h0,2'd0,1,16'd0);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            a_rst = vt[i].rst; a_iv = vt[i].iv;
            a_d = vt[i].d; a_c = vt[i].c;
            a_bub = vt[i].bub; a_fl = vt[i].fl;
            a_ordy = vt[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.ov", i), 64'(a_ov), 64'(vt[i].ov));
            chk($sformatf("v%0d.od", i), a_od, vt[i].od);
            chk($sformatf("v%0d.oc", i), 64'(a_oc), 64'(vt[i].oc));
            chk($sformatf("v%0d.occ", i), 64'(a_occ), 64'(vt[i].occ));
            chk($sformatf("v%0d.ir", i), 64'(a_ir), 64'(vt[i].ir));
            chk($sformatf("v%0d.sc", i), 64'(a_sc), 64'(vt[i].sc));
        end

        // Instance B: reset
        @(negedge clk);
        b_rst = 0;
        #1;
        chk("b.rst.ov", 64'(b_ov), 64'd0);
        chk("b.rst.ir", 64'(b_ir), 64'd1);
        chk("b.rst.sc", 64'(b_sc), 64'd0);
        // accept one beat, then stall 20 cycles
        b_iv = 1; b_d = 64'h5; b_c = 16'h1; b_ordy = 0;
        @(posedge clk);
        #1;
        chk("b.acc.ov", 64'(b_ov), 64'd1);
        chk("b.acc.od", b_od, 64'h5);
        chk("b.stall.ir", 64'(b_ir), 64'd0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 15 || k == 16 || k == 20)
                chk($sformatf("b.sat%0d", k), 64'(b_sc), 64'd15);
        end
        chk("b.hold.od", b_od, 64'h5);
        chk("b.hold.occ", 64'(b_occ), 64'd1);
        // same-cycle replace: ready passes through combinationally
        @(negedge clk);
        b_ordy = 1; b_d = 64'h6; b_c = 16'h2;
        #1;
        chk("b.comb.ir", 64'(b_ir), 64'd1);
        @(posedge clk);
        #1;
        chk("b.rep1.od", b_od, 64'h6);
        chk("b.rep1.oc", 64'(b_oc), 64'h2);
        chk("b.rep1.ov", 64'(b_ov), 64'd1);
        @(negedge clk);
        b_d = 64'h7; b_c = 16'h3;
        @(posedge clk);
        #1;
        chk("b.rep2.od", b_od, 64'h7);
        chk("b.rep2.occ", 64'(b_occ), 64'd1);
        @(negedge clk);
        b_iv = 0;
        @(posedge clk);
        #1;
        chk("b.drain.ov", 64'(b_ov), 64'd0);
        chk("b.drain.oc", 64'(b_oc), 64'd0);
        chk("b.drain.sc", 64'(b_sc), 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline-stage register; the generic successor to the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Carries a data payload plus a control bundle between any two pipeline stages.
- Uses a valid/ready handshake, with an optional 2-entry skid buffer for full throughput under back-pressure.
- Supports synchronous flush and bubble insertion, which force the control bundle to a NOP pattern, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 64, payload width (register values, immediates, PC); never altered by bubble or flush.
- CTRL_W, 16, control-bundle width (RF_LE, L, RAM_CTRL, ALU_OP, …).
- BUBBLE_CTRL, {CTRL_W{1'b0}}, control pattern presented for a bubble, an empty stage, and after flush or reset.
- SKID, 1, selects the buffer depth:
  - 1: two entries (main + skid); in_ready is a registered output.
  - 0: single entry; in_ready = ~out_valid | out_ready (combinational).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous and active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- bubble  in  1  on an accepted beat, replaces in_ctrl with BUBBLE_CTRL; payload is kept.
- flush  in  1  discards every held beat and any beat accepted this cycle.
- out_valid  out  1  stage holds a beat for downstream.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  head-entry payload.
- out_ctrl  out  CTRL_W  head-entry control; equals BUBBLE_CTRL whenever out_valid=0.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Definitions: acc = in_valid & in_ready; pop = out_valid & out_ready. Evaluated each rising edge.
- Reset (synchronous, highest priority):
  - state becomes EMPTY; out_valid=0; out_data=0; out_ctrl=BUBBLE_CTRL; occupancy=0; stall_cnt=0.
  - in_ready=1 in the cycle after reset releases, in both SKID modes.
- Flush (priority below reset, above all handshakes):
  - state becomes EMPTY; out_valid=0; out_ctrl=BUBBLE_CTRL; out_data holds its last value.
  - A beat accepted in the same cycle (acc=1) is dropped.
  - A pop in the flush cycle completes normally; downstream has already sampled it.
  - stall_cnt is unaffected.
- States, SKID=1 (M = main register, S = skid register):
  - EMPTY, acc: M<=in, go to ONE.
  - ONE, acc & ~pop: S<=in, go to TWO.
  - ONE, acc & pop: M<=in, stay in ONE.
  - ONE, ~acc & pop: go to EMPTY.
  - ONE, neither: hold.
  - TWO, pop: M<=S, go to ONE. No accept is possible in TWO.
  - TWO, no pop: hold.
  - in_ready = (state != TWO), decoded from registered state only; there is no combinational path from out_ready.
- States, SKID=0:
  - EMPTY/ONE only.
  - acc & (EMPTY or pop): M<=in.
  - pop & ~acc: go to EMPTY.
- Bubble:
  - The stored ctrl is BUBBLE_CTRL when bubble=1 at accept; otherwise it is in_ctrl.
  - Bubble with in_valid=0 has no effect.
  - Bubbled beats are valid beats: they occupy an entry and obey the handshake.
- Outputs:
  - out_data/out_ctrl always reflect M.
  - Latency: 1 cycle from accept into an empty stage to out_valid=1.
  - Ordering is strictly FIFO; no beat is duplicated or lost except by flush.
- stall_cnt:
  - Increments by 1 on every cycle with out_valid & ~out_ready.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- Back-pressure:
  - Upstream must hold in_valid/in_data/in_ctrl stable while in_valid & ~in_ready.
  - Upstream dropping in_valid without acceptance is legal; no state change results.
- Sustained throughput with out_ready=1: one beat per cycle in both SKID modes.

Test Plan:
- Reset → out_valid=0, out_ctrl=BUBBLE_CTRL(0x0000), out_data=0, occupancy=0, stall_cnt=0; in_ready=1 in the cycle after reset releases.
- Streaming (SKID=1), out_ready=1, beats data=1..8 with ctrl=0x0011 on consecutive cycles → out_data=1..8 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1.
- Back-pressure (SKID=1):
  - Stimulus: accept A=0xAA and B=0xBB, hold out_ready=0 for 5 cycles, then release.
  - Required: occupancy=2 and in_ready=0 after B; stall_cnt=5; A then B appear on out_data with nothing lost or duplicated.
- Bubble: accept data=0x1234, ctrl=0x00FF, bubble=1 → out_data=0x1234, out_ctrl=0x0000, out_valid=1.
- Flush (SKID=1):
  - Stimulus: occupancy=2, flush=1 together with in_valid=1 carrying 0xCC.
  - Required: next cycle occupancy=0, out_valid=0, out_ctrl=0x0000; 0xCC never appears on the output.
- Saturation and SKID=0 mode:
  - CNT_W=4, stall for 20 cycles → stall_cnt=15 with no wrap.
  - SKID=0, out_valid=1, out_ready=1 → in_ready=1 the same cycle; the new beat replaces the old one with no gap.
